// File: rtl/srambank_req_ctrl.sv
// srambank_req_ctrl: zero-fills an SRAM bank after reset, then turns a request stream into bank strobes
// and buffers read data in a credit-protected response FIFO.
module srambank_req_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 64,
    parameter int RSP_DEPTH = 4,
    parameter int INIT_EN   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              init_done,
    output logic [ADDR_W-1:0] mem_ADDRESS,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_banksel,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_dataout
);
    localparam int PW = $clog2(RSP_DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] fifo [RSP_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count, credit;
    logic rd_pending, pop;

    // An in-flight read already owns a FIFO slot, so it counts against the credit.
    assign credit    = count + (PW+1)'(rd_pending);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = count != '0;
    assign rsp_data  = fifo[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= (INIT_EN != 0) ? INIT : RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        mem_banksel = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_ADDRESS = req_addr;
        mem_wd      = req_wdata;
        if (state == INIT) begin
            mem_banksel = 1'b1;
            mem_write   = 1'b1;
            mem_ADDRESS = cnt;
            mem_wd      = '0;
            state_nxt   = (cnt == {ADDR_W{1'b1}}) ? RUN : INIT;
        end else begin
            req_ready   = credit < (PW+1)'(RSP_DEPTH);
            mem_banksel = req_valid && req_ready;
            mem_write   = mem_banksel && req_we;
            mem_read    = mem_banksel && !req_we;
        end
        if (reset) begin
            req_ready   = 1'b0;
            mem_banksel = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
        end
    end

    // Bank dataout is valid the cycle after a read fires; capture it one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_pending <= 1'b0;
            init_done  <= 1'b0;
            for (int i = 0; i < RSP_DEPTH; i++) fifo[i] <= '0;
        end else begin
            if (state == INIT) cnt <= cnt + ADDR_W'(1);
            init_done  <= init_done || (state_nxt == RUN);
            rd_pending <= mem_read;
            if (rd_pending) begin
                fifo[wr_ptr] <= mem_dataout;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(rd_pending) - (PW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_srambank_req_ctrl.sv
// tb_srambank_req_ctrl: directed requests against a behavioural bank model; a scoreboard queue
// holds the expected read data and a monitor compares on every response handshake.
module tb_srambank_req_ctrl;
    logic        clk = 0, reset = 1, req_valid = 0, req_we = 0, rsp_ready = 0;
    logic [9:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        req_ready, rsp_valid, init_done, mem_banksel, mem_read, mem_write;
    logic [63:0] rsp_data, mem_wd, mem_dataout;
    logic [9:0]  mem_ADDRESS;
    logic [63:0] bank [1024];
    logic [63:0] exp_q [$];
    int          pop_log [$];
    int          checks = 0, failures = 0, cyc = 0, stalls = 0;

    srambank_req_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .init_done(init_done), .mem_ADDRESS(mem_ADDRESS), .mem_wd(mem_wd),
        .mem_banksel(mem_banksel), .mem_read(mem_read), .mem_write(mem_write), .mem_dataout(mem_dataout)
    );

    always #5 clk = ~clk;

    // Behavioural bank: write completes at the edge, dataout updates only on a read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_banksel && mem_write) bank[mem_ADDRESS] <= mem_wd;
        if (mem_banksel && mem_read) mem_dataout <= bank[mem_ADDRESS];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_read && mem_write) begin
            failures++;
            $display("FAIL rw_both: read and write high together at cycle %0d", cyc);
        end
        if (!reset && rsp_valid && rsp_ready) begin
            pop_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: got %h expected no response", rsp_data);
            end else check("rsp_data", rsp_data, exp_q.pop_front());
        end
    end

    task automatic issue(input logic we, input logic [9:0] a, input logic [63:0] d, input logic [63:0] e);
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (req_ready) begin
                if (!we) exp_q.push_back(e);
                break;
            end
            stalls++;
            if (t > 200) begin
                failures++;
                $display("FAIL issue_timeout: addr %h never accepted", a);
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_left", 64'(exp_q.size()), 0);
    endtask

    task automatic check_fill();
        int bad = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (!(mem_banksel && mem_write && !mem_read && mem_ADDRESS == 10'(i) && mem_wd == 0
                  && !req_ready && !init_done)) bad++;
        end
        check("fill_bad_cycles", 64'(bad), 0);
        @(negedge clk);
        check("init_done_after_fill", 64'(init_done), 1);
        check("ready_after_fill", 64'(req_ready), 1);
        check("banksel_idle", 64'(mem_banksel), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2;
        check("rst_req_ready", 64'(req_ready), 0);
        check("rst_rsp_valid", 64'(rsp_valid), 0);
        check("rst_init_done", 64'(init_done), 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_banksel", 64'(mem_banksel), 0);
        @(posedge clk); #1;
        reset = 0;
        check_fill();

        rsp_ready = 1;
        issue(1, 10'h155, 64'hDEADBEEF_CAFEF00D, 0);
        issue(0, 10'h155, 0, 64'hDEADBEEF_CAFEF00D);
        check("lat_after_fire", 64'(rsp_valid), 0);
        @(posedge clk); #1;
        check("lat_two_edges", 64'(rsp_valid), 1);
        drain();

        issue(0, 10'h3FF, 0, 0);
        drain();

        for (int a = 0; a < 16; a++) issue(1, 10'(a), 64'(a * 3), 0);
        stalls = 0;
        pop_log.delete();
        for (int a = 0; a < 16; a++) issue(0, 10'(a), 0, 64'(a * 3));
        drain();
        check("stream_stalls", 64'(stalls), 0);
        check("stream_rsp_count", 64'(pop_log.size()), 16);
        if (pop_log.size() == 16) check("stream_span", 64'(pop_log[15] - pop_log[0]), 15);

        rsp_ready = 0;
        stalls = 0;
        for (int a = 0; a < 4; a++) issue(0, 10'(a), 0, 64'(a * 3));
        check("bp_four_accepted", 64'(stalls), 0);
        begin
            int acc = 0;
            req_valid = 1; req_we = 0; req_addr = 10'd4;
            repeat (5) begin
                @(negedge clk);
                if (req_ready) acc++;
            end
            check("bp_ready_low", 64'(acc), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1;
        issue(0, 10'd4, 0, 64'd12);
        issue(0, 10'd5, 0, 64'd15);
        drain();

        rsp_ready = 0;
        issue(0, 10'd7, 0, 64'd21);
        issue(0, 10'd8, 0, 64'd24);
        issue(0, 10'd9, 0, 64'd27);
        check("mid_rsp_valid", 64'(rsp_valid), 1);
        req_valid = 1; req_we = 1;
        reset = 1;
        exp_q.delete();
        #1;
        check("mid_rsp_valid_drop", 64'(rsp_valid), 0);
        check("mid_banksel", 64'(mem_banksel), 0);
        check("mid_req_ready", 64'(req_ready), 0);
        check("mid_init_done", 64'(init_done), 0);
        @(posedge clk); #1;
        check("mid_banksel_held", 64'(mem_banksel), 0);
        req_valid = 0;
        reset = 0;
        check_fill();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/srambank_req_ctrl.md
Name: srambank_req_ctrl

Overview:
- Request front-end that sits directly upstream of one srambank_256x4x64_6t122 instance.
- After reset it zero-fills the whole bank, then converts a valid/ready request stream into the bank's banksel/read/write/ADDRESS/wd strobes.
- Read data returned by the bank is captured into a small response FIFO with valid/ready backpressure.
- Credit logic guarantees no read data is ever lost. The bank has no stall and updates dataout only on a read.

Parameters:
- ADDR_W, 10, bank address width; the bank holds 2^ADDR_W words.
- DATA_W, 64, data width.
- RSP_DEPTH, 4, response FIFO entries; must be a power of two and at least 3.
- INIT_EN, 1, 1 = zero-fill the bank after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted at the clock edge where req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  read data available at the FIFO head.
- rsp_ready  in  1  consumer accepts the head entry.
- rsp_data  out  DATA_W  read data at the FIFO head.
- init_done  out  1  high once the zero-fill is complete; stays high until the next reset.
- mem_ADDRESS  out  ADDR_W  drives the bank ADDRESS input.
- mem_wd  out  DATA_W  drives the bank wd input.
- mem_banksel  out  1  drives the bank banksel input.
- mem_read  out  1  drives the bank read input.
- mem_write  out  1  drives the bank write input.
- mem_dataout  in  DATA_W  the bank's dataout.

Behaviour:
- Reset values (asynchronous):
  - State machine to INIT, or to RUN if INIT_EN=0.
  - Fill counter = 0, FIFO empty, rd_pending = 0.
  - req_ready = 0, rsp_valid = 0, init_done = 0, rsp_data = 0.
  - While reset is high, mem_banksel, mem_read and mem_write are forced to 0 combinationally.
- States: INIT, RUN. There is no other state.
- INIT:
  - Each cycle: mem_banksel = 1, mem_write = 1, mem_read = 0, mem_ADDRESS = counter, mem_wd = 0.
  - The counter increments every edge.
  - At the edge where counter = 2^ADDR_W - 1, the block moves to RUN and sets init_done.
  - A fill therefore takes exactly 2^ADDR_W cycles.
  - req_ready is 0 throughout INIT.
- RUN, ready and credit:
  - req_ready = (fifo_count + rd_pending) < RSP_DEPTH.
  - This is registered-state only; there is no same-cycle pop credit.
  - req_ready does not depend on req_valid or req_we.
- RUN, bank drive (combinational from the request):
  - mem_banksel = req_valid && req_ready.
  - mem_write = fire && req_we.
  - mem_read = fire && !req_we.
  - mem_ADDRESS = req_addr and mem_wd = req_wdata.
  - read and write are never both high.
  - When not firing, mem_banksel = 0; address and data are don't-care.
- Read latency:
  - A read that fires at edge T is sampled by the bank at T.
  - mem_dataout is valid during cycle T..T+1.
  - The data is pushed into the FIFO at edge T+1, and rsp_valid is high from T+1.
  - Total latency is 2 edges, accept to rsp_valid.
  - rd_pending is set at T and cleared at T+1 unless a new read fires at T+1.
- Writes:
  - No response. The write completes at its fire edge.
  - A read to the same address on the next cycle returns the new data.
- Ordering: responses return in request order.
- FIFO:
  - Pop when rsp_valid && rsp_ready. A simultaneous push and pop leaves the count unchanged.
  - Push into a full FIFO cannot occur because of the credit rule. The verifier asserts this.
  - rsp_data holds the head entry and is stable while rsp_valid && !rsp_ready.
- Throughput: with rsp_ready held at 1, back-to-back reads sustain one per cycle (requires RSP_DEPTH >= 3).
- Reset mid-operation:
  - Asynchronous abort. FIFO contents and any pending read are discarded.
  - The zero-fill restarts from address 0.
  - Bank contents are undefined until the new fill completes.
- Address wrap: req_addr is used as-is; no range check is needed, since 2^ADDR_W equals the bank size.

Test Plan:
- Zero-fill:
  - Stimulus: release reset, INIT_EN=1.
  - Required: 1024 consecutive write strobes to addresses 0..1023 with wd = 0; init_done rises after edge 1024; req_ready = 0 until then.
- Write then read-back:
  - Stimulus: write 0xDEADBEEF_CAFEF00D to address 0x155, then read address 0x155 on the next cycle.
  - Required: rsp_valid two edges after the read fires; rsp_data = 0xDEADBEEF_CAFEF00D.
- Post-fill read:
  - Stimulus: read address 0x3FF, never written.
  - Required: rsp_data = 0.
- Streaming reads:
  - Stimulus: 16 back-to-back reads of addresses 0..15 (previously written with the value addr*3), rsp_ready = 1.
  - Required: req_ready never drops; 16 responses in order, with values 0, 3, ..., 45, on consecutive cycles.
- Backpressure:
  - Stimulus: rsp_ready = 0, 6 reads offered.
  - Required: exactly 4 reads accepted, then req_ready = 0; after rsp_ready goes to 1, 4 in-order responses, then the remaining 2 reads accepted.
- Reset mid-stream:
  - Stimulus: assert reset while 2 responses are queued and 1 read is pending.
  - Required: rsp_valid drops immediately; mem_banksel = 0 during reset; a new 1024-cycle fill starts at address 0 after release.
